// File: rtl/atom_field_serializer.sv
// Serializes 1/2/4/8-byte fields into a byte stream with valid/ready handshakes on both sides.
// Optional header byte (8'hA0 | kind) before each field when ATOM_FIELD_SERIALIZER_HEADER_EN is defined.
module atom_field_serializer #(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_kind,
   input  logic [63:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_last,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   state_t      state_reg;
   logic [1:0]  kind_reg;
   logic [63:0] data_reg;
   logic [2:0]  cnt_reg;
   logic        out_valid_reg;
   logic        out_last_reg;
   logic [7:0]  out_data_reg;

   logic [2:0]  kind_last;
   logic [2:0]  cnt_next;
   logic        out_hs;

   // Index of the final payload byte: n-1 for n = 1, 2, 4, 8.
   function automatic logic [2:0] last_idx(input logic [1:0] k);
      case (k)
         2'd0:    return 3'd0;
         2'd1:    return 3'd1;
         2'd2:    return 3'd3;
         default: return 3'd7;
      endcase
   endfunction

   function automatic logic [7:0] lane(input logic [63:0] d, input logic [2:0] last,
                                       input logic [2:0] c);
      logic [2:0] idx;
      idx = BIG_ENDIAN ? 3'(last - c) : c;
      return d[{idx, 3'b000} +: 8];
   endfunction

   assign kind_last = last_idx(kind_reg);
   assign cnt_next  = cnt_reg + 3'd1;
   assign out_hs    = out_valid_reg && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         kind_reg      <= 2'd0;
         data_reg      <= 64'd0;
         cnt_reg       <= 3'd0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         out_data_reg  <= 8'h00;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  kind_reg      <= in_kind;
                  data_reg      <= in_data;
                  cnt_reg       <= 3'd0;
                  out_valid_reg <= 1'b1;
`ifdef ATOM_FIELD_SERIALIZER_HEADER_EN
                  state_reg     <= HDR;
                  out_data_reg  <= 8'hA0 | {6'd0, in_kind};
                  out_last_reg  <= 1'b0;
`else
                  state_reg     <= DATA;
                  out_data_reg  <= lane(in_data, last_idx(in_kind), 3'd0);
                  out_last_reg  <= (last_idx(in_kind) == 3'd0);
`endif
               end
            end
            HDR: begin
               if (out_hs) begin
                  state_reg    <= DATA;
                  out_data_reg <= lane(data_reg, kind_last, 3'd0);
                  out_last_reg <= (kind_last == 3'd0);
               end
            end
            DATA: begin
               if (out_hs) begin
                  if (cnt_reg == kind_last) begin
                     state_reg     <= IDLE;
                     cnt_reg       <= 3'd0;
                     out_valid_reg <= 1'b0;
                     out_last_reg  <= 1'b0;
                     out_data_reg  <= 8'h00;
                  end else begin
                     cnt_reg      <= cnt_next;
                     out_data_reg <= lane(data_reg, kind_last, cnt_next);
                     out_last_reg <= (cnt_next == kind_last);
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_last  = out_last_reg;

endmodule

// File: tb/tb_atom_field_serializer.sv
// Self-checking bench for atom_field_serializer: little- and big-endian instances driven in parallel.
// Honours ATOM_FIELD_SERIALIZER_HEADER_EN to expect the header byte.
module tb_atom_field_serializer;
`ifdef ATOM_FIELD_SERIALIZER_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [1:0]  in_kind;
   logic [63:0] in_data;
   logic        in_ready_le, out_valid_le, out_last_le, busy_le;
   logic        in_ready_be, out_valid_be, out_last_be, busy_be;
   logic [7:0]  out_data_le, out_data_be;
   logic [11:0] st_le, st_be;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0]  kind;
      logic [63:0] data;
      logic [63:0] exp_le;
      logic [63:0] exp_be;
      int          hold;
   } vec_t;
   vec_t tbl[7];

   always #5 clk = ~clk;

   atom_field_serializer #(.BIG_ENDIAN(1'b0)) dut_le (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_le),
      .in_kind(in_kind), .in_data(in_data), .out_valid(out_valid_le),
      .out_ready(out_ready), .out_data(out_data_le), .out_last(out_last_le),
      .busy(busy_le));

   atom_field_serializer #(.BIG_ENDIAN(1'b1)) dut_be (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_be),
      .in_kind(in_kind), .in_data(in_data), .out_valid(out_valid_be),
      .out_ready(out_ready), .out_data(out_data_be), .out_last(out_last_be),
      .busy(busy_be));

   assign st_le = {out_valid_le, out_last_le, in_ready_le, busy_le, out_data_le};
   assign st_be = {out_valid_be, out_last_be, in_ready_be, busy_be, out_data_be};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Emission order packed low byte first: byte i of the stream is r[8i +: 8].
   function automatic logic [63:0] model_emit(input logic [63:0] d, input logic [1:0] k,
                                              input bit be);
      int n;
      int src;
      logic [63:0] r;
      n = 1 << k;
      r = 64'd0;
      for (int i = 0; i < n; i++) begin
         src = be ? (n - 1 - i) : i;
         r[i*8 +: 8] = d[src*8 +: 8];
      end
      return r;
   endfunction

   task automatic wait_ready(input string tag);
      int t;
      t = 0;
      while (!(in_ready_le && in_ready_be) && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t == 50) chk({tag, "_ready_timeout"}, 32'(in_ready_le), 32'd1);
   endtask

   task automatic run_field(input string tag, input logic [1:0] k, input logic [63:0] d,
                            input logic [63:0] el, input logic [63:0] eb,
                            input int stall_pct, input int hold_last);
      int n, total, stalls, j;
      logic [7:0] bl, bb;
      logic lst;
      bit rdy;
      n = 1 << k;
      total = n + HDR;
      wait_ready(tag);
      in_valid = 1'b1;
      in_kind = k;
      in_data = d;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      in_kind = 2'($urandom);
      in_data = {$urandom, $urandom};
      for (int i = 0; i < total; i++) begin
         j = i - HDR;
         if (j < 0) begin
            bl = 8'hA0 | {6'd0, k};
            bb = bl;
            lst = 1'b0;
         end else begin
            bl = el[j*8 +: 8];
            bb = eb[j*8 +: 8];
            lst = (j == n - 1);
         end
         stalls = (i == total - 1) ? hold_last : 0;
         rdy = 1'b0;
         for (int c = 0; c < 64 && !rdy; c++) begin
            chk({tag, "_le"}, 32'(st_le), 32'({1'b1, lst, 1'b0, 1'b1, bl}));
            chk({tag, "_be"}, 32'(st_be), 32'({1'b1, lst, 1'b0, 1'b1, bb}));
            rdy = (stalls == 0) && ($urandom_range(99) >= stall_pct);
            if (stalls > 0) stalls--;
            out_ready = rdy;
            @(negedge clk);
         end
      end
      out_ready = 1'b0;
      chk({tag, "_idle_le"}, 32'(st_le[11:8]), 32'(4'b0010));
      chk({tag, "_idle_be"}, 32'(st_be[11:8]), 32'(4'b0010));
   endtask

   task automatic back_to_back();
      int acc, hs;
      int acc_cyc[2];
      int hs_cyc[2];
      logic [7:0] vals[2];
      vals[0] = 8'h3C;
      vals[1] = 8'hC3;
      acc = 0;
      hs = 0;
      acc_cyc[0] = 0; acc_cyc[1] = 0;
      hs_cyc[0] = 0;  hs_cyc[1] = 0;
      wait_ready("b2b");
      in_valid = 1'b1;
      in_kind = 2'd0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && hs < 2; cyc++) begin
         if (acc == 2) in_valid = 1'b0;
         else if (in_ready_le) begin
            in_data = {56'd0, vals[acc]};
            acc_cyc[acc] = cyc;
            acc++;
         end
         if (out_valid_le && out_last_le) begin
            chk("b2b_data_le", 32'(out_data_le), 32'(vals[hs]));
            chk("b2b_data_be", 32'(out_data_be), 32'(vals[hs]));
            hs_cyc[hs] = cyc;
            hs++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("b2b_count", 32'(hs), 32'd2);
      chk("b2b_gap", 32'(acc_cyc[1] - hs_cyc[0]), 32'd1);
   endtask

   task automatic reset_mid_field();
      wait_ready("rstmid");
      in_valid = 1'b1;
      in_kind = 2'd2;
      in_data = 64'h0000_0000_A1B2_C3D4;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (HDR + 2) @(negedge clk);
      chk("rstmid_byte2_le", 32'(out_data_le), 32'h0000_00B2);
      chk("rstmid_byte2_be", 32'(out_data_be), 32'h0000_00C3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstmid_after_le", 32'(st_le), 32'h0000_0200);
      chk("rstmid_after_be", 32'(st_be), 32'h0000_0200);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rstmid_quiet", 32'({out_valid_le, out_valid_be}), 32'd0);
      end
      out_ready = 1'b0;
      run_field("rstmid_next", 2'd2, 64'h0000_0000_A1B2_C3D4,
                64'h0000_0000_A1B2_C3D4, 64'h0000_0000_D4C3_B2A1, 0, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  rk;
      logic [63:0] rd;
      tbl[0] = '{2'd2, 64'h0000_0000_1122_3344, 64'h0000_0000_1122_3344, 64'h0000_0000_4433_2211, 0};
      tbl[1] = '{2'd1, 64'hFFFF_FFFF_FFFF_ABCD, 64'h0000_0000_0000_ABCD, 64'h0000_0000_0000_CDAB, 0};
      tbl[2] = '{2'd3, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708, 64'h0807_0605_0403_0201, 0};
      tbl[3] = '{2'd0, 64'h0000_0000_0000_005A, 64'h0000_0000_0000_005A, 64'h0000_0000_0000_005A, 3};
      tbl[4] = '{2'd1, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_DEF0, 64'h0000_0000_0000_F0DE, 0};
      tbl[5] = '{2'd2, 64'hDEAD_BEEF_CAFE_BABE, 64'h0000_0000_CAFE_BABE, 64'h0000_0000_BEBA_FECA, 1};
      tbl[6] = '{2'd0, 64'hFFFF_FFFF_FFFF_FF00, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 0};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_kind = 2'd0;
      in_data = 64'd0;
      repeat (2) @(negedge clk);
      chk("reset_hold_le", 32'({out_valid_le, out_last_le, busy_le, out_data_le}), 32'd0);
      chk("reset_hold_be", 32'({out_valid_be, out_last_be, busy_be, out_data_be}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_release_le", 32'(st_le), 32'h0000_0200);
      chk("reset_release_be", 32'(st_be), 32'h0000_0200);

      for (int v = 0; v < 7; v++)
         run_field($sformatf("vec%0d", v), tbl[v].kind, tbl[v].data,
                   tbl[v].exp_le, tbl[v].exp_be, 0, tbl[v].hold);

      back_to_back();
      reset_mid_field();

      for (int r = 0; r < 40; r++) begin
         rk = 2'($urandom_range(3));
         rd = {$urandom, $urandom};
         run_field($sformatf("rnd%0d", r), rk, rd, model_emit(rd, rk, 1'b0),
                   model_emit(rd, rk, 1'b1), 30, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
